// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache controller: address field layout,
// block geometry, FSM state encoding and a byte-select helper.
package dcache_ctrl_pkg;

    localparam int ADDR_W     = 8;
    localparam int TAG_W      = 3;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;
    localparam int TAG_LSB    = 5;
    localparam int IDX_LSB    = 2;
    localparam int BLOCK_W    = 32;
    localparam int MEM_ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE_BACK = 2'd1,
        ST_FETCH      = 2'd2,
        ST_UPDATE     = 2'd3
    } state_t;

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                              input logic [OFF_W-1:0]   off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Storage for the direct-mapped cache: per-block valid, dirty, tag and data.
// Lookup is combinational; byte write, block fill and clear-all are
// synchronous. Clear-all only touches valid/dirty, never tag/data.
module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int NBLOCKS     = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         clear_all,
    input  logic [$clog2(NBLOCKS)-1:0]   index,
    input  logic                         byte_we,
    input  logic [$clog2(BLOCK_BYTES)-1:0] offset,
    input  logic [7:0]                   byte_data,
    input  logic                         fill_we,
    input  logic [TAG_W-1:0]             fill_tag,
    input  logic [BLOCK_BYTES*8-1:0]     fill_data,
    output logic                         line_valid,
    output logic                         line_dirty,
    output logic [TAG_W-1:0]             line_tag,
    output logic [BLOCK_BYTES*8-1:0]     line_data
);

    logic [NBLOCKS-1:0]         valid_q;
    logic [NBLOCKS-1:0]         dirty_q;
    logic [TAG_W-1:0]           tag_mem  [NBLOCKS];
    logic [BLOCK_BYTES*8-1:0]   data_mem [NBLOCKS];

    // Status bits: clear-all wins over fill, fill wins over a store.
    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag and data contents; not reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[index]  <= fill_tag;
            data_mem[index] <= fill_data;
        end else if (byte_we) begin
            data_mem[index][{offset, 3'b000} +: 8] <= byte_data;
        end
    end

    // Combinational lookup of the indexed block.
    always_comb begin
        line_valid = valid_q[index];
        line_dirty = dirty_q[index];
        line_tag   = tag_mem[index];
        line_data  = data_mem[index];
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; misses write back a dirty victim,
// refill the block from dmem and stall the CPU through busywait.
//
// Memory handshake: a request (mem_read or mem_write) is held high with a
// stable mem_address/mem_writedata until a rising edge on which
// mem_busywait is 0; that edge completes the transfer (and for a read,
// captures mem_readdata). The request drops the cycle after. mem_read and
// mem_write are never high together.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NBLOCKS     = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [7:0]            writedata,
    output logic [7:0]            readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait,
    output logic [1:0]            state_dbg
);

    state_t               state, next_state;
    logic [TAG_W-1:0]     addr_tag;
    logic [IDX_W-1:0]     addr_idx;
    logic [OFF_W-1:0]     addr_off;
    logic                 line_valid, line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [BLOCK_W-1:0]   line_data;
    logic [BLOCK_W-1:0]   fetch_buf;
    logic                 req, hit;
    logic                 byte_we, fill_we;

    assign addr_tag  = address[TAG_LSB +: TAG_W];
    assign addr_idx  = address[IDX_LSB +: IDX_W];
    assign addr_off  = address[OFF_W-1:0];
    assign req       = read | write;
    assign hit       = line_valid && (line_tag == addr_tag);
    assign state_dbg = state;

    dcache_array #(
        .NBLOCKS     (NBLOCKS),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_array (
        .clk        (CLK),
        .clear_all  (RESET),
        .index      (addr_idx),
        .byte_we    (byte_we),
        .offset     (addr_off),
        .byte_data  (writedata),
        .fill_we    (fill_we),
        .fill_tag   (addr_tag),
        .fill_data  (fetch_buf),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Capture the refill block on the edge that completes the fetch.
    always_ff @(posedge CLK) begin
        if (state == ST_FETCH && !mem_busywait) fetch_buf <= mem_readdata;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req && !hit) begin
                    if (line_valid && line_dirty) next_state = ST_WRITE_BACK;
                    else                          next_state = ST_FETCH;
                end
            end
            ST_WRITE_BACK: if (!mem_busywait) next_state = ST_FETCH;
            ST_FETCH:      if (!mem_busywait) next_state = ST_UPDATE;
            ST_UPDATE:     next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // Outputs: memory requests, CPU stall/data, array write strobes.
    // A simultaneous read and write is handled as a write, so no read data.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        fill_we       = 1'b0;
        byte_we       = 1'b0;
        readdata      = 8'h00;
        busywait      = req && ((state != ST_IDLE) || !hit);
        case (state)
            ST_IDLE: begin
                byte_we = write && hit;
                if (read && !write && hit) readdata = block_byte(line_data, addr_off);
            end
            ST_WRITE_BACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, addr_idx};
                mem_writedata = line_data;
            end
            ST_FETCH: begin
                mem_read    = 1'b1;
                mem_address = {addr_tag, addr_idx};
            end
            ST_UPDATE: fill_we = 1'b1;
            default: ;
        endcase
    end

endmodule
